sr_rx_ctrl: RTL
===============

Name: sr_rx_ctrl

Overview:
Controller that sequences a WIDTH-bit serial-in shift register to receive framed serial data on a single line (idle high, start bit 0, WIDTH data bits LSB-first, one stop bit 1). It oversamples the line at DIV clocks per bit, drives the shift-enable timing, tracks the bit count and delivers the parallel word with a one-cycle valid strobe. It sits between the raw serial input pin and the downstream parallel consumer, and owns the shift register it controls.

Parameters:
WIDTH, 4, data bits per frame and width of the shift register (2..16)
DIV, 4, clocks per bit period; must be even and >= 2

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
in  input  1  asynchronous serial line, idle high
enable  input  1  receive enable; gates only frame start
data  output  WIDTH  last correctly framed word
data_valid  output  1  one-cycle pulse when data is updated
frame_err  output  1  one-cycle pulse on stop-bit error
busy  output  1  high in every state except IDLE
shift_en  output  1  one-cycle pulse on each data-bit shift
bit_cnt  output  clog2(WIDTH+1)  data bits shifted in the current frame

Behaviour:
- Reset (reset=0, async): state=IDLE; data, data_valid, frame_err, busy, shift_en, bit_cnt, shift register, bit counter, synchronizer flops (to 1) all cleared/idle immediately, independent of clk.
- in passes a 2-flop synchronizer -> in_s; all decisions use in_s.
- States: IDLE, START, DATA, STOP, WAIT_HI. One clock-divider counter cnt, reset on every state entry.
- IDLE: if enable=1 and in_s=0 -> START (edge t0). enable=0 -> stay IDLE regardless of line.
- START: at cnt=DIV/2-1 sample in_s: 0 -> DATA, bit_cnt=0; 1 -> IDLE (glitch, no pulses, no error).
- DATA: every DIV clocks sample in_s; shreg <= {in_s, shreg[WIDTH-1:1]}; shift_en=1 that cycle; bit_cnt++. After the WIDTH-th shift -> STOP.
- STOP: after DIV clocks sample in_s: 1 -> data<=shreg, data_valid=1 for one cycle, -> IDLE; 0 -> frame_err=1 for one cycle, data unchanged, -> WAIT_HI.
- WAIT_HI: stay until in_s=1, then -> IDLE (prevents a low line re-triggering start).
- Timing relative to t0: start sample t0+DIV/2, data samples t0+DIV/2+k*DIV (k=1..WIDTH), stop sample t0+DIV/2+(WIDTH+1)*DIV; data/data_valid/frame_err registered, visible the cycle after the stop sample.
- data_valid and frame_err never both high; shift_en never high outside DATA.
- enable deasserted mid-frame: current frame completes normally; new frames blocked.
- Back-to-back: after a good stop sample the controller is in IDLE mid-stop-bit and detects the next start edge without loss.
- bit_cnt holds its final value until the next START->DATA transition.
- Reset mid-frame: abort, outputs to reset values, partial word discarded.

Test Plan:
- WIDTH=4, DIV=4, send frame with data 4'hA (bits 0,1,0,1 LSB-first), stop=1 -> exactly 4 shift_en pulses 4 clocks apart, data=4'hA, single data_valid pulse, bit_cnt=4, busy low after.
- Line low for 1 clock only while IDLE -> START entered, returns IDLE at midpoint; no shift_en, data_valid or frame_err; data unchanged.
- Frame 4'h5 with stop bit 0, line held low 10 more bit times -> frame_err one pulse, data keeps previous 4'hA, busy high until line returns high, no spurious restart.
- Assert reset=0 asynchronously after 2nd data bit -> all outputs 0 same instant, no clk needed; after release a clean frame 4'h3 received correctly.
- enable=0 with frames on line -> no busy, no pulses; enable dropped after start bit of frame 4'hC -> frame completes, data=4'hC.
- Back-to-back frames 4'h3 then 4'hC with no idle gap -> two data_valid pulses, data=4'h3 then 4'hC, no frame_err.

Source files
------------

// File: rtl/sr_rx_ctrl.sv
// rtl/sr_rx_ctrl.sv - oversampling serial receive controller driving a serial-in shift register
module sr_rx_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in,
  input  logic                       enable,
  output logic [WIDTH-1:0]           data,
  output logic                       data_valid,
  output logic                       frame_err,
  output logic                       busy,
  output logic                       shift_en,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             sync1;
  logic             in_s;

  // Two-flop synchronizer for the asynchronous line; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      in_s  <= 1'b1;
    end else begin
      sync1 <= in;
      in_s  <= sync1;
    end
  end

  // Frame sequencer: mid-bit sampling, shift-register control and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      shift_en   <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      shift_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !in_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == CW'(DIV / 2 - 1)) begin
            cnt <= '0;
            if (!in_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              // Low pulse shorter than half a bit: treat as noise, no error.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt      <= '0;
            shreg    <= {in_s, shreg[WIDTH-1:1]};
            shift_en <= 1'b1;
            bit_cnt  <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(WIDTH - 1)) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
            if (in_s) begin
              // Back to IDLE mid stop bit so an immediately following start edge is caught.
              data       <= shreg;
              data_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HI;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HI: begin
          // A line stuck low after a bad stop bit must not retrigger a frame.
          if (in_s) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
